// File: rtl/mp_pkg.sv
// Shared definitions for the teaching microprocessor: opcodes, control strobe
// bundle and the decode/immediate helpers used by the control/ALU core.
package mp_pkg;

    localparam int unsigned WORD_W = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;

    typedef struct packed {
        logic reg_dst;
        logic reg_write;
        logic alu_src;
        logic branch;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_op;
    } ctrl_t;

    // Every 2-bit opcode is legal, so the decode is a complete table.
    function automatic ctrl_t decode_op(input logic [1:0] op);
        ctrl_t c;
        c = '0;
        unique case (op)
            OP_ADD: begin
                c.reg_dst   = 1'b1;
                c.reg_write = 1'b1;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.alu_src    = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            OP_SW: begin
                c.alu_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            OP_J: begin
                c.branch = 1'b1;
                c.alu_op = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [WORD_W-1:0] sign_ext_imm(input logic [1:0] field);
        return {{(WORD_W - 1){field[1]}}, field[0]};
    endfunction

endpackage

// File: rtl/mp_clk_div.sv
// Divides the board oscillator into a 50 % duty processor clock; clk_out
// toggles every HALF_PERIOD rising edges of clk_in.
module mp_clk_div #(
    parameter int unsigned HALF_PERIOD = 25_000_000
) (
    input  logic clk_in,
    input  logic reset,
    output logic clk_out
);

    localparam int unsigned CntW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(HALF_PERIOD - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            clk_q, clk_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        clk_d = clk_q;
        if (cnt_q == CntMax) begin
            cnt_d = '0;
            clk_d = ~clk_q;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            clk_q <= clk_d;
        end
    end

    assign clk_out = clk_q;

endmodule

// File: rtl/mp_ctrl_alu.sv
// Control decode, immediate sign-extension and adder-only ALU of the 8-bit
// teaching processor, plus the processor clock divider.
module mp_ctrl_alu
    import mp_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 25_000_000
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic [WORD_W-1:0] instruction,
    input  logic [WORD_W-1:0] reg_data1,
    input  logic [WORD_W-1:0] reg_data2,
    output logic              clk_out,
    output logic              reg_dst,
    output logic              reg_write,
    output logic              alu_src,
    output logic              branch,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_to_reg,
    output logic              alu_op,
    output logic [WORD_W-1:0] imm,
    output logic [WORD_W-1:0] alu_result
);

    ctrl_t             ctrl;
    logic [WORD_W-1:0] operand2;

    mp_clk_div #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_clk_div (
        .clk_in (clk_in),
        .reset  (reset),
        .clk_out(clk_out)
    );

    always_comb begin
        ctrl = decode_op(instruction[7:6]);
        imm  = sign_ext_imm(instruction[1:0]);
    end

    assign reg_dst    = ctrl.reg_dst;
    assign reg_write  = ctrl.reg_write;
    assign alu_src    = ctrl.alu_src;
    assign branch     = ctrl.branch;
    assign mem_read   = ctrl.mem_read;
    assign mem_write  = ctrl.mem_write;
    assign mem_to_reg = ctrl.mem_to_reg;
    assign alu_op     = ctrl.alu_op;

    // alu_op is informational only; the ALU always adds and drops the carry.
    assign operand2   = ctrl.alu_src ? imm : reg_data2;
    assign alu_result = reg_data1 + operand2;

endmodule

// File: tb/tb_mp_ctrl_alu.sv
// Directed bench: exhaustive decode/immediate sweep, ALU vectors, and divider
// timing for HALF_PERIOD of 3 and 1.
module tb_mp_ctrl_alu;

    logic       clk_in;
    logic       reset;
    logic [7:0] instruction, reg_data1, reg_data2;

    logic       clk_out3, clk_out1;
    logic       reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg, alu_op;
    logic [7:0] imm, alu_result;

    logic       u1_reg_dst, u1_reg_write, u1_alu_src, u1_branch;
    logic       u1_mem_read, u1_mem_write, u1_mem_to_reg, u1_alu_op;
    logic [7:0] u1_imm, u1_alu_result;

    int n_checks = 0;
    int n_pass   = 0;

    mp_ctrl_alu #(.HALF_PERIOD(3)) dut3 (
        .clk_in     (clk_in),
        .reset      (reset),
        .instruction(instruction),
        .reg_data1  (reg_data1),
        .reg_data2  (reg_data2),
        .clk_out    (clk_out3),
        .reg_dst    (reg_dst),
        .reg_write  (reg_write),
        .alu_src    (alu_src),
        .branch     (branch),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_to_reg (mem_to_reg),
        .alu_op     (alu_op),
        .imm        (imm),
        .alu_result (alu_result)
    );

    mp_ctrl_alu #(.HALF_PERIOD(1)) dut1 (
        .clk_in     (clk_in),
        .reset      (reset),
        .instruction(instruction),
        .reg_data1  (reg_data1),
        .reg_data2  (reg_data2),
        .clk_out    (clk_out1),
        .reg_dst    (u1_reg_dst),
        .reg_write  (u1_reg_write),
        .alu_src    (u1_alu_src),
        .branch     (u1_branch),
        .mem_read   (u1_mem_read),
        .mem_write  (u1_mem_write),
        .mem_to_reg (u1_mem_to_reg),
        .alu_op     (u1_alu_op),
        .imm        (u1_imm),
        .alu_result (u1_alu_result)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [7:0] strobes();
        return {reg_dst, reg_write, alu_src, branch, mem_read, mem_write, mem_to_reg, alu_op};
    endfunction

    initial begin
        logic [7:0] exp_ctrl;
        logic [7:0] exp_imm;

        reset       = 1'b1;
        instruction = 8'h00;
        reg_data1   = 8'h00;
        reg_data2   = 8'h00;

        // Reset state, with clk_in edges arriving while reset is held.
        #12;
        check("reset_clk_out_hp3", {31'b0, clk_out3}, 32'd0);
        check("reset_clk_out_hp1", {31'b0, clk_out1}, 32'd0);

        // Exhaustive decode and immediate sweep.
        for (int i = 0; i < 256; i++) begin
            instruction = 8'(i);
            #1;
            case (instruction[7:6])
                2'b00:   exp_ctrl = 8'b1100_0000;
                2'b01:   exp_ctrl = 8'b0110_1010;
                2'b10:   exp_ctrl = 8'b0010_0100;
                default: exp_ctrl = 8'b0001_0001;
            endcase
            case (instruction[1:0])
                2'b00:   exp_imm = 8'h00;
                2'b01:   exp_imm = 8'h01;
                2'b10:   exp_imm = 8'hFE;
                default: exp_imm = 8'hFF;
            endcase
            check($sformatf("ctrl_%02h", i), {24'b0, strobes()}, {24'b0, exp_ctrl});
            check($sformatf("imm_%02h", i), {24'b0, imm}, {24'b0, exp_imm});
        end

        // ALU vectors.
        instruction = 8'h1B; reg_data1 = 8'h7F; reg_data2 = 8'h01; #1;
        check("add_7f_01", {24'b0, alu_result}, 32'h80);
        reg_data1 = 8'hFF; reg_data2 = 8'h02; #1;
        check("add_wrap", {24'b0, alu_result}, 32'h01);
        instruction = 8'h42; reg_data1 = 8'h05; reg_data2 = 8'h33; #1;
        check("lw_alu_src", {31'b0, alu_src}, 32'd1);
        check("lw_imm_neg2", {24'b0, alu_result}, 32'h03);
        instruction = 8'h83; reg_data1 = 8'h10; reg_data2 = 8'hAA; #1;
        check("sw_imm_neg1", {24'b0, alu_result}, 32'h0F);
        instruction = 8'hC1; reg_data1 = 8'h10; reg_data2 = 8'h20; #1;
        check("j_uses_rt", {24'b0, alu_result}, 32'h30);
        check("alu_hp1_copy", {24'b0, u1_alu_result}, 32'h30);

        // Release reset away from a rising edge, then track edges 1..9.
        @(negedge clk_in);
        reset = 1'b0;
        for (int e = 1; e <= 9; e++) begin
            @(posedge clk_in);
            #1;
            check($sformatf("hp3_edge%0d", e), {31'b0, clk_out3}, 32'((e / 3) % 2));
            check($sformatf("hp1_edge%0d", e), {31'b0, clk_out1}, 32'(e % 2));
        end

        // clk_out3 is high; one more edge leaves the counter mid-count.
        @(posedge clk_in);
        #1;
        check("hp3_high_before_reset", {31'b0, clk_out3}, 32'd1);
        #1;
        reset = 1'b1;
        #0;
        #1;
        check("hp3_async_reset", {31'b0, clk_out3}, 32'd0);
        @(negedge clk_in);
        reset = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk_in);
            #1;
            check($sformatf("hp3_restart_edge%0d", e), {31'b0, clk_out3}, 32'(e / 3));
            check($sformatf("hp1_restart_edge%0d", e), {31'b0, clk_out1}, 32'(e % 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
